mem_responder: RTL and testbench

Memory-side responder for the per-channel valid/ready memory protocol driven by the memory controller. It accepts read and write requests on `NUM_CHANNELS` channels, services each after a fixed latency from a shared word-addressed storage array, and holds the ready handshake until the requester drops valid. It stands in for external data or program memory in simulation and in FPGA builds, and sits directly on the controller's memory-side ports.

---
 rtl/responder_states_pkg.sv | 16 +
 rtl/mem_responder_channel.sv | 90 +++++++++
 rtl/mem_responder.sv | 81 ++++++++
 tb/tb_mem_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/responder_states_pkg.sv
// rtl/responder_states_pkg.sv - channel states, request kinds and stall LFSR constants for mem_responder
package responder_states_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RESPOND} responder_state_e;
   typedef enum logic {READ, WRITE} req_kind_e;

   localparam int         CNT_BITS  = 16;
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/mem_responder_channel.sv
// rtl/mem_responder_channel.sv - one request channel: accept, fixed-latency wait, hold ready until valid drops
module mem_responder_channel
   import responder_states_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 2,
   parameter int WRITE_ENABLE  = 1
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 read_valid,
   input  logic [ADDR_BITS-1:0] read_address,
   input  logic                 write_valid,
   input  logic [ADDR_BITS-1:0] write_address,
   input  logic [DATA_BITS-1:0] write_data,
   input  logic [1:0]           extra_cycles,
   input  logic [DATA_BITS-1:0] mem_rdata,
   output logic                 read_ready,
   output logic [DATA_BITS-1:0] read_data,
   output logic                 write_ready,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   output logic                 commit
);

   responder_state_e    state;
   req_kind_e           kind;
   logic [CNT_BITS-1:0] count;
   logic                action;

   assign action = (state == BUSY) && (count == '0);
   // The top commits mem_wdata to mem_addr on the edge this strobe is high
   assign commit = action && (kind == WRITE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         kind        <= READ;
         count       <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         read_ready  <= 1'b0;
         read_data   <= '0;
         write_ready <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (read_valid) begin
                  mem_addr <= read_address;
                  kind     <= READ;
                  count    <= CNT_BITS'(READ_LATENCY - 1) + CNT_BITS'(extra_cycles);
                  state    <= BUSY;
               end else if (write_valid && (WRITE_ENABLE != 0)) begin
                  mem_addr  <= write_address;
                  mem_wdata <= write_data;
                  kind      <= WRITE;
                  count     <= CNT_BITS'(WRITE_LATENCY - 1) + CNT_BITS'(extra_cycles);
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (action) begin
                  if (kind == READ) begin
                     read_data  <= mem_rdata;
                     read_ready <= 1'b1;
                  end else begin
                     write_ready <= 1'b1;
                  end
                  state <= RESPOND;
               end else begin
                  count <= count - CNT_BITS'(1);
               end
            end
            RESPOND: begin
               if ((kind == READ) ? !read_valid : !write_valid) begin
                  read_ready  <= 1'b0;
                  read_data   <= '0;
                  write_ready <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multi-channel fixed-latency memory responder; MEM_RESPONDER_STALL_EN adds LFSR stalls
module mem_responder
   import responder_states_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16,
   parameter int NUM_CHANNELS  = 1,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 2,
   parameter int WRITE_ENABLE  = 1
)
(
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_CHANNELS-1:0]                read_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address,
   output logic [NUM_CHANNELS-1:0]                read_ready,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data,
   input  logic [NUM_CHANNELS-1:0]                write_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data,
   output logic [NUM_CHANNELS-1:0]                write_ready
);

   logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_addr;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_wdata;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_rdata;
   logic [NUM_CHANNELS-1:0]                ch_commit;
   logic [1:0]                             extra_cycles;

`ifdef MEM_RESPONDER_STALL_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lfsr <= LFSR_SEED;
      else        lfsr <= lfsr_next(lfsr);
   end

   assign extra_cycles = lfsr[1:0];
`else
   assign extra_cycles = 2'b00;
`endif

   // Ascending loop: the highest-index channel's commit lands last and wins
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (ch_commit[i]) mem[ch_addr[i]] <= ch_wdata[i];
      end
   end

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      assign ch_rdata[i] = mem[ch_addr[i]];

      mem_responder_channel #(
         .ADDR_BITS     (ADDR_BITS),
         .DATA_BITS     (DATA_BITS),
         .READ_LATENCY  (READ_LATENCY),
         .WRITE_LATENCY (WRITE_LATENCY),
         .WRITE_ENABLE  (WRITE_ENABLE)
      ) u_channel (
         .clk           (clk),
         .reset         (reset),
         .read_valid    (read_valid[i]),
         .read_address  (read_address[i]),
         .write_valid   (write_valid[i]),
         .write_address (write_address[i]),
         .write_data    (write_data[i]),
         .extra_cycles  (extra_cycles),
         .mem_rdata     (ch_rdata[i]),
         .read_ready    (read_ready[i]),
         .read_data     (read_data[i]),
         .write_ready   (write_ready[i]),
         .mem_addr      (ch_addr[i]),
         .mem_wdata     (ch_wdata[i]),
         .commit        (ch_commit[i])
      );
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized bench for mem_responder against a timestamp-based reference model
module tb_mem_responder;

   localparam int AB = 8;
   localparam int DB = 16;
   localparam int NC = 2;
   localparam int RL = 2;
   localparam int WL = 2;
`ifdef MEM_RESPONDER_STALL_EN
   localparam bit STALL = 1'b1;
`else
   localparam bit STALL = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [NC-1:0]         rv = '0, wv = '0, rr, wr;
   logic [NC-1:0][AB-1:0] ra = '0, wa = '0;
   logic [NC-1:0][DB-1:0] wd = '0, rd;

   logic [0:0]         ro_rv = '0, ro_wv = '0, ro_rr, ro_wr;
   logic [0:0][AB-1:0] ro_ra = '0, ro_wa = '0;
   logic [0:0][DB-1:0] ro_wd = '0, ro_rd;

   mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC),
                   .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WRITE_ENABLE(1)) dut (
      .clk(clk), .reset(reset),
      .read_valid(rv), .read_address(ra), .read_ready(rr), .read_data(rd),
      .write_valid(wv), .write_address(wa), .write_data(wd), .write_ready(wr));

   mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(1),
                   .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WRITE_ENABLE(0)) dut_ro (
      .clk(clk), .reset(reset),
      .read_valid(ro_rv), .read_address(ro_ra), .read_ready(ro_rr), .read_data(ro_rd),
      .write_valid(ro_wv), .write_address(ro_wa), .write_data(ro_wd), .write_ready(ro_wr));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each request is a record with an absolute completion edge number
   typedef struct {
      int             phase;   // 0 free, 1 waiting for due edge, 2 answered
      bit             is_wr;
      logic [AB-1:0]  a;
      logic [DB-1:0]  d;
      int             due;
   } req_t;

   req_t          m_req [NC];
   logic [DB-1:0] m_mem [256];
   bit            m_known [256];
   logic [7:0]    m_lfsr;
   int            edge_no = 0;
   logic [NC-1:0] e_rr, e_wr;
   logic [DB-1:0] e_rd [NC];
   bit            e_rd_known [NC];

   function automatic void model_reset();
      for (int i = 0; i < NC; i++) begin
         m_req[i].phase = 0;
         e_rd[i]        = '0;
         e_rd_known[i]  = 1'b1;
      end
      e_rr   = '0;
      e_wr   = '0;
      m_lfsr = 8'hA5;
   endfunction

   always @(negedge reset) model_reset();

   always @(posedge clk) begin
      if (reset) begin
         int            extra;
         bit            do_commit [NC];
         extra = STALL ? int'(m_lfsr[1:0]) : 0;
         edge_no++;
         for (int i = 0; i < NC; i++) begin
            do_commit[i] = 1'b0;
            if (m_req[i].phase == 0) begin
               if (rv[i]) begin
                  m_req[i].phase = 1; m_req[i].is_wr = 1'b0; m_req[i].a = ra[i];
                  m_req[i].due = edge_no + RL + extra;
               end else if (wv[i]) begin
                  m_req[i].phase = 1; m_req[i].is_wr = 1'b1; m_req[i].a = wa[i];
                  m_req[i].d = wd[i]; m_req[i].due = edge_no + WL + extra;
               end
            end else if (m_req[i].phase == 1) begin
               if (edge_no == m_req[i].due) begin
                  m_req[i].phase = 2;
                  if (m_req[i].is_wr) begin
                     e_wr[i]      = 1'b1;
                     do_commit[i] = 1'b1;
                  end else begin
                     e_rr[i]       = 1'b1;
                     e_rd[i]       = m_mem[m_req[i].a];
                     e_rd_known[i] = m_known[m_req[i].a];
                  end
               end
            end else begin
               if (m_req[i].is_wr ? !wv[i] : !rv[i]) begin
                  m_req[i].phase = 0;
                  e_rr[i] = 1'b0; e_wr[i] = 1'b0;
                  e_rd[i] = '0;   e_rd_known[i] = 1'b1;
               end
            end
         end
         // Reads above saw the old contents; commits land afterwards, higher index last
         for (int i = 0; i < NC; i++) begin
            if (do_commit[i]) begin
               m_mem[m_req[i].a]   = m_req[i].d;
               m_known[m_req[i].a] = 1'b1;
            end
         end
         m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NC; i++) begin
         check($sformatf("model_read_ready[%0d]", i), 32'(rr[i]), 32'(e_rr[i]));
         check($sformatf("model_write_ready[%0d]", i), 32'(wr[i]), 32'(e_wr[i]));
         if (e_rd_known[i])
            check($sformatf("model_read_data[%0d]", i), 32'(rd[i]), 32'(e_rd[i]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int ch, input bit is_wr, output int lat);
      lat = 0;
      while (!(is_wr ? wr[ch] : rr[ch]) && lat < 20) begin
         tick();
         lat++;
      end
      if (lat >= 20) begin
         total++; bad++;
         $display("FAIL ready_timeout ch=%0d actual=0 required=1", ch);
      end
   endtask

   task automatic do_write(input int ch, input logic [AB-1:0] a, input logic [DB-1:0] d, output int lat);
      wv[ch] = 1'b1; wa[ch] = a; wd[ch] = d;
      tick();
      wait_ready(ch, 1'b1, lat);
      wv[ch] = 1'b0;
      tick();
   endtask

   task automatic do_read(input int ch, input logic [AB-1:0] a, output logic [DB-1:0] d, output int lat);
      rv[ch] = 1'b1; ra[ch] = a;
      tick();
      wait_ready(ch, 1'b0, lat);
      d = rd[ch];
      rv[ch] = 1'b0;
      tick();
   endtask

   task automatic requester(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         int kind;
         bit got;
         repeat ($urandom_range(0, 3)) tick();
         kind   = $urandom_range(0, 2);
         ra[ch] = 8'h40 + 8'($urandom_range(0, 7));
         wa[ch] = 8'h40 + 8'($urandom_range(0, 7));
         wd[ch] = 16'($urandom);
         rv[ch] = (kind != 1);
         wv[ch] = (kind != 0);
         got = 1'b0;
         for (int c = 0; c < 30 && !got; c++) begin
            tick();
            got = rv[ch] ? rr[ch] : wr[ch];
            if (!got) begin
               ra[ch] = 8'($urandom);
               wa[ch] = 8'($urandom);
               wd[ch] = 16'($urandom);
            end
         end
         check($sformatf("random_done[%0d]", ch), 32'(got), 32'd1);
         repeat ($urandom_range(0, 2)) tick();
         rv[ch] = 1'b0;
         wv[ch] = 1'b0;
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int            lat;
      logic [DB-1:0] d;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_read_ready", 32'(rr), 32'd0);
      check("reset_write_ready", 32'(wr), 32'd0);
      check("reset_read_data", 32'(rd), 32'd0);
      reset = 1'b1;

      // First accept after reset: stall adds lfsr 8'hA5 [1:0] = 1 cycle
      do_read(0, 8'h10, d, lat);
      check("first_read_latency", 32'(lat), STALL ? 32'd3 : 32'd2);

      do_write(0, 8'h10, 16'h00AA, lat);

      // ch1 holds a read response while ch0 is mid-BUSY writing 0x1234
      rv[1] = 1'b1; ra[1] = 8'h10;
      tick();
      wait_ready(1, 1'b0, lat);
      wv[0] = 1'b1; wa[0] = 8'h10; wd[0] = 16'h1234;
      tick();
      #2 reset = 1'b0;
      #1;
      check("async_reset_read_ready", 32'(rr), 32'd0);
      check("async_reset_read_data", 32'(rd), 32'd0);
      check("async_reset_write_ready", 32'(wr), 32'd0);
      rv = '0; wv = '0;
      tick();
      reset = 1'b1;
      do_read(0, 8'h10, d, lat);
      check("interrupted_write_kept_old", 32'(d), 32'h00AA);

      do_write(0, 8'h05, 16'hBEEF, lat);
`ifndef MEM_RESPONDER_STALL_EN
      check("write_latency", 32'(lat), 32'd2);
`endif
      do_read(0, 8'h05, d, lat);
      check("read_back_beef", 32'(d), 32'hBEEF);
`ifndef MEM_RESPONDER_STALL_EN
      check("read_latency", 32'(lat), 32'd2);
`endif

      // Valid held 3 cycles past ready
      rv[0] = 1'b1; ra[0] = 8'h05;
      tick();
      wait_ready(0, 1'b0, lat);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold_read_ready", 32'(rr[0]), 32'd1);
         check("hold_read_data", 32'(rd[0]), 32'hBEEF);
      end
      rv[0] = 1'b0;
      tick();
      check("release_read_ready", 32'(rr[0]), 32'd0);
      check("release_read_data", 32'(rd[0]), 32'd0);

      // Same-edge write collision
      wv = 2'b11; wa[0] = 8'h20; wa[1] = 8'h20; wd[0] = 16'h1111; wd[1] = 16'h2222;
      tick();
      wait_ready(0, 1'b1, lat);
      check("collision_ch1_ready", 32'(wr[1]), 32'd1);
      wv = '0;
      tick();
      do_read(0, 8'h20, d, lat);
      check("collision_winner", 32'(d), 32'h2222);

      // Read-only instance ignores writes
      ro_wv[0] = 1'b1; ro_wa[0] = 8'h03; ro_wd[0] = 16'h0F0F;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("ro_write_ready", 32'(ro_wr[0]), 32'd0);
      end
      ro_wv[0] = 1'b0;
      tick();
      ro_rv[0] = 1'b1; ro_ra[0] = 8'h03;
      lat = 0;
      tick();
      while (!ro_rr[0] && lat < 20) begin
         tick();
         lat++;
      end
      check("ro_read_ready", 32'(ro_rr[0]), 32'd1);
      total++;
      if (ro_rd[0] === 16'h0F0F) begin
         bad++;
         $display("FAIL ro_contents actual=%h required=not 0f0f", ro_rd[0]);
      end
      ro_rv[0] = 1'b0;
      tick();

      fork
         requester(0, 60);
         requester(1, 60);
      join

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
